// File: rtl/mc14500_pc_seq_pkg.sv
// mc14500_pkg: shared types and helpers for the MC14500 program sequencer.
//   pc_state_e - sequencer state (RUN / SKIP / HALT); 2'd3 is illegal and
//                recovers to RUN.
//   sp_width   - stack-pointer width for a given number of stack entries.
//   depth_width- width of a counter that holds 0..entries inclusive.
package mc14500_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SKIP = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    // Pointer into a power-of-two circular buffer; never narrower than 1 bit.
    function automatic int sp_width(input int entries);
        return (entries <= 2) ? 1 : $clog2(entries);
    endfunction

    function automatic int depth_width(input int entries);
        return $clog2(entries + 1);
    endfunction

endpackage

// File: rtl/mc14500_pc_seq_if.sv
// mc14500_pc_seq_if: flag/operand inputs and status outputs of the sequencer.
//   master - drives latched ICU flags, resume and jump target; observes status.
//   slave  - the sequencer: consumes flags, produces pc/skip/halted/depth/stack_err.
interface mc14500_pc_seq_if #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic              jmp;
    logic              rtn;
    logic              flg0;
    logic              flgf;
    logic              resume;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic              skip;
    logic              halted;
    logic [DW-1:0]     depth;
    logic              stack_err;

    modport master (
        output jmp, rtn, flg0, flgf, resume, target,
        input  pc, skip, halted, depth, stack_err
    );

    modport slave (
        input  jmp, rtn, flg0, flgf, resume, target,
        output pc, skip, halted, depth, stack_err
    );
endinterface

// File: rtl/mc14500_pc_seq_ret_stack.sv
// mc14500_ret_stack: circular return-address LIFO.
//   clk1, rstb1     - clock, async active-low reset (clears depth/pointer/err)
//   push_i, data_i  - push data_i; when full the oldest entry is overwritten
//   pop_i           - pop top entry (ignored when empty)
//   top_o           - current top-of-stack value (valid when depth_o != 0)
//   depth_o         - number of valid entries
//   err_o           - sticky overflow flag, cleared only by reset
// push_i and pop_i are never asserted together by the sequencer.
module mc14500_ret_stack
    import mc14500_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk1,
    input  logic                               rstb1,
    input  logic                               push_i,
    input  logic                               pop_i,
    input  logic [ADDR_W-1:0]                  data_i,
    output logic [ADDR_W-1:0]                  top_o,
    output logic [depth_width(STACK_DEPTH)-1:0] depth_o,
    output logic                               err_o
);
    localparam int SPW = sp_width(STACK_DEPTH);
    localparam int DW  = depth_width(STACK_DEPTH);

    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [SPW-1:0]    sp_q;     // next write slot
    logic [DW-1:0]     depth_q;
    logic              err_q;
    logic              full;

    assign full = (depth_q == DW'(STACK_DEPTH));

    // When full, sp_q already points at the oldest entry, so a plain write
    // there both overwrites the oldest and keeps the ring consistent.
    always_ff @(posedge clk1 or negedge rstb1) begin
        if (!rstb1) begin
            sp_q    <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else if (push_i) begin
            sp_q <= sp_q + SPW'(1);
            if (full) err_q   <= 1'b1;
            else      depth_q <= depth_q + DW'(1);
        end else if (pop_i && depth_q != '0) begin
            sp_q    <= sp_q - SPW'(1);
            depth_q <= depth_q - DW'(1);
        end
    end

    // Storage carries no reset; contents are don't-care until pushed.
    always_ff @(posedge clk1) begin
        if (push_i) mem_q[sp_q] <= data_i;
    end

    assign top_o   = mem_q[sp_q - SPW'(1)];
    assign depth_o = depth_q;
    assign err_o   = err_q;

endmodule

// File: rtl/mc14500_pc_seq.sv
// mc14500_pc_seq: MC14500 program sequencer with return-address stack.
//   clk1, rstb1 - clock, async active-low reset
//   bus (slave) - jmp/rtn/flg0/flgf/resume/target in;
//                 pc/skip/halted/depth/stack_err out (all registered)
// RUN priority: call (jmp&flg0) > jump > return > empty-return skip > +1.
// flgf additionally sends RUN to HALT after the pc update.
module mc14500_pc_seq
    import mc14500_pkg::*;
#(
    parameter int              ADDR_W      = 8,
    parameter int              STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic             clk1,
    input  logic             rstb1,
    mc14500_pc_seq_if.slave  bus
);
    localparam int DW = depth_width(STACK_DEPTH);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, stk_top;
    logic [DW-1:0]     stk_depth;
    logic              stk_err, push, pop;

    assign pc_inc = pc_q + ADDR_W'(1);   // wraps silently

    mc14500_ret_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
        .clk1    (clk1),
        .rstb1   (rstb1),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc),
        .top_o   (stk_top),
        .depth_o (stk_depth),
        .err_o   (stk_err)
    );

    always_ff @(posedge clk1 or negedge rstb1) begin
        if (!rstb1) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.jmp && bus.flg0) begin
                    push = 1'b1;
                    pc_d = bus.target;
                end else if (bus.jmp) begin
                    pc_d = bus.target;
                end else if (bus.rtn && stk_depth != '0) begin
                    pop  = 1'b1;
                    pc_d = stk_top;
                end else if (bus.rtn) begin
                    pc_d    = pc_inc;
                    state_d = ST_SKIP;
                end else begin
                    pc_d = pc_inc;
                end
                // Halt overrides a pending skip.
                if (bus.flgf) state_d = ST_HALT;
            end
            // Flags here belong to the suppressed instruction.
            ST_SKIP: begin
                pc_d    = pc_inc;
                state_d = ST_RUN;
            end
            // pc holds on the resume edge; counting restarts next edge.
            ST_HALT: begin
                if (bus.resume) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        bus.pc        = pc_q;
        bus.skip      = (state_q == ST_SKIP);
        bus.halted    = (state_q == ST_HALT);
        bus.depth     = stk_depth;
        bus.stack_err = stk_err;
    end

endmodule
